// File: rtl/mux_share_arbiter.sv
// Round-robin owner arbiter for a shared 2:1 WIDTH-bit select datapath.
// Grants are registered; data_out/valid_out trail the grant by one cycle.
module mux_share_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    state_t           state, state_nxt;
    side_t            last, last_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             sel_nxt;
    logic             entering;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a variable unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        hold_cnt_nxt = hold_cnt;
        sel_nxt      = sel;
        entering     = 1'b0;

        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_nxt = (last == SIDE_A) ? OWN_B : OWN_A;
                end else if (req_a) begin
                    state_nxt = OWN_A;
                end else if (req_b) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    state_nxt = req_b ? OWN_B : IDLE;
                end else if (req_b && (hold_cnt == HOLD_LAST)) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_nxt = req_a ? OWN_A : IDLE;
                end else if (req_a && (hold_cnt == HOLD_LAST)) begin
                    state_nxt = OWN_A;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Any change of owner (including a direct A<->B handover) restarts the hold window.
        entering = (state_nxt != state) && (state_nxt != IDLE);
        if (entering) begin
            hold_cnt_nxt = '0;
            last_nxt     = (state_nxt == OWN_B) ? SIDE_B : SIDE_A;
        end else if ((state != IDLE) && (hold_cnt != HOLD_LAST)) begin
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end

        if (state_nxt == OWN_A) begin
            sel_nxt = 1'b0;
        end else if (state_nxt == OWN_B) begin
            sel_nxt = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= SIDE_B;
            hold_cnt <= '0;
            sel      <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_cnt_nxt;
            sel      <= sel_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (gnt_a || gnt_b) begin
            data_out  <= sel ? data_b : data_a;
            valid_out <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

    assign gnt_a = (state == OWN_A);
    assign gnt_b = (state == OWN_B);

endmodule
